// File: rtl/cpu_fetch_unit.sv
// cpu_fetch_unit
// Instruction fetch stage sitting directly after the branch logic. It owns the
// architectural fetch PC, issues one word request at a time to instruction
// memory, and holds one fetched instruction for decode behind a valid/ready
// handshake. A taken redirect (pc_src 01/10) restarts fetch at the selected
// target and discards any response still in flight for the old path.
//
// Optional feature: define CPU_FETCH_MISALIGN_EN to add the if_misalign output.
// A redirect to a target that is not word aligned then delivers a NOP tagged as
// misaligned instead of fetching, and fetch halts until the next redirect.
// Without the macro, the two low target bits are cleared before use.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   pc_src             00 PC+4, 01 pc_target, 10 alu_result, 11 treated as 00
//   pc_target          branch / JAL target
//   alu_result         JALR target
//   imem_req_*         request channel: valid/ready handshake, word address
//   imem_resp_*        response channel: one response per accepted request
//   if_valid/if_ready  handshake towards decode
//   if_instr, if_pc    buffered instruction and its address
//   if_pc_plus_4       if_pc + 4 (wraps modulo 2^XLEN)
//   if_misalign        only with CPU_FETCH_MISALIGN_EN
module cpu_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] pc_target,
  input  logic [XLEN-1:0] alu_result,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus_4
`ifdef CPU_FETCH_MISALIGN_EN
  ,
  output logic            if_misalign
`endif
);

  typedef enum logic [1:0] {REQ, WAIT, STALE} state_t;

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);
`ifdef CPU_FETCH_MISALIGN_EN
  localparam logic [XLEN-1:0] NOP  = XLEN'(32'h0000_0013);
`endif

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

  state_t          state, state_nxt;
  logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
  logic            buf_valid, buf_valid_nxt;
  logic [XLEN-1:0] instr_q, instr_nxt;
  logic [XLEN-1:0] pc_q, pc_nxt;
  logic            redirect;
  logic [XLEN-1:0] target;
  logic            req_fire;
  logic            dec_fire;
  logic            fetch_halted;
`ifdef CPU_FETCH_MISALIGN_EN
  logic            halted, halted_nxt;
  logic            misalign_q, misalign_nxt;
`endif

  always_comb begin
    redirect = (pc_src == 2'b01) || (pc_src == 2'b10);
    target   = (pc_src == 2'b10) ? alu_result : pc_target;
  end

`ifdef CPU_FETCH_MISALIGN_EN
  assign fetch_halted = halted;
  assign if_misalign  = misalign_q;
`else
  assign fetch_halted = 1'b0;
`endif

  // Request only when the buffer is free or being drained this cycle, so a
  // returning response always has somewhere to land. rst_n gating keeps the
  // request low while reset is held.
  assign imem_req_valid = rst_n && (state == REQ) && (!buf_valid || if_ready)
                          && !redirect && !fetch_halted;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign dec_fire       = buf_valid && if_ready;

  assign if_valid     = buf_valid;
  assign if_instr     = instr_q;
  assign if_pc        = pc_q;
  assign if_pc_plus_4 = pc_q + FOUR;

  always_comb begin
    state_nxt     = state;
    fetch_pc_nxt  = fetch_pc;
    buf_valid_nxt = buf_valid;
    instr_nxt     = instr_q;
    pc_nxt        = pc_q;
`ifdef CPU_FETCH_MISALIGN_EN
    halted_nxt    = halted;
    misalign_nxt  = misalign_q;
`endif

    if (dec_fire) buf_valid_nxt = 1'b0;

    case (state)
      REQ: begin
        if (req_fire) state_nxt = WAIT;
      end
      WAIT: begin
        // A response refills the buffer even if decode drains it this cycle.
        if (imem_resp_valid) begin
          state_nxt     = REQ;
          buf_valid_nxt = 1'b1;
          instr_nxt     = imem_resp_data;
          pc_nxt        = fetch_pc;
          fetch_pc_nxt  = fetch_pc + FOUR;
`ifdef CPU_FETCH_MISALIGN_EN
          misalign_nxt  = 1'b0;
`endif
        end
      end
      STALE: begin
        // Response of the abandoned path: swallow it and resume.
        if (imem_resp_valid) state_nxt = REQ;
      end
      default: state_nxt = REQ;
    endcase

    // Redirect overrides everything above. An outstanding request that has
    // not answered yet leaves us in STALE to absorb its response; one that
    // answers in the redirect cycle is simply dropped.
    if (redirect) begin
      buf_valid_nxt = 1'b0;
      instr_nxt     = instr_q;
      pc_nxt        = pc_q;
      state_nxt     = ((state == REQ) || imem_resp_valid) ? REQ : STALE;
`ifdef CPU_FETCH_MISALIGN_EN
      fetch_pc_nxt  = target;
      if (target[1:0] != 2'b00) begin
        buf_valid_nxt = 1'b1;
        instr_nxt     = NOP;
        pc_nxt        = target;
        misalign_nxt  = 1'b1;
        halted_nxt    = 1'b1;
      end else begin
        misalign_nxt  = 1'b0;
        halted_nxt    = 1'b0;
      end
`else
      fetch_pc_nxt  = word_align(target);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= REQ;
      fetch_pc  <= RESET_PC;
      buf_valid <= 1'b0;
      instr_q   <= '0;
      pc_q      <= '0;
`ifdef CPU_FETCH_MISALIGN_EN
      halted     <= 1'b0;
      misalign_q <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      fetch_pc  <= fetch_pc_nxt;
      buf_valid <= buf_valid_nxt;
      instr_q   <= instr_nxt;
      pc_q      <= pc_nxt;
`ifdef CPU_FETCH_MISALIGN_EN
      halted     <= halted_nxt;
      misalign_q <= misalign_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Testbench for cpu_fetch_unit: directed cycle table, hand-written reset
// sequence and randomized traffic against a transaction-level model.
module tb_cpu_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] XMASK    = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  pc_src;
  logic [31:0] pc_target, alu_result;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc, if_pc_plus_4;
`ifdef CPU_FETCH_MISALIGN_EN
  logic        if_misalign;
`endif

  cpu_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .pc_target(pc_target),
    .alu_result(alu_result), .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc_plus_4(if_pc_plus_4)
`ifdef CPU_FETCH_MISALIGN_EN
    , .if_misalign(if_misalign)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory: one response per accepted request, data = addr ^ A5A5_0000.
  bit          mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;

  task automatic drive_mem();
    imem_resp_valid = mem_busy && (mem_cnt == 0);
    imem_resp_data  = imem_resp_valid ? (mem_addr ^ XMASK) : 32'hDEAD_BEEF;
  endtask

  // Called mid-cycle with inputs applied; returns at the next falling edge.
  task automatic advance(input int lat);
    bit fire, rsp;
    logic [31:0] a;
    fire = imem_req_valid && imem_req_ready;
    rsp  = imem_resp_valid;
    a    = imem_req_addr;
    @(posedge clk);
    if (rsp) mem_busy = 1'b0;
    if (fire) begin
      mem_busy = 1'b1;
      mem_cnt  = lat - 1;
      mem_addr = a;
    end else if (mem_busy && mem_cnt > 0) begin
      mem_cnt--;
    end
    @(negedge clk);
    drive_mem();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pc_src = 2'b00; pc_target = '0; alu_result = '0;
    imem_req_ready = 1'b0; if_ready = 1'b0;
    mem_busy = 1'b0; mem_cnt = 0;
    drive_mem();
    #1;
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_if_valid", if_valid, 1'b0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  ps;
    logic [31:0] tg, al;
    bit          rr, ir;
    int          lat;
    bit          rv;
    logic [31:0] addr;
    bit          iv;
    logic [31:0] instr, pc;
    bit          mis;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] ps, input logic [31:0] tg, input logic [31:0] al,
                     input bit rr, input bit ir, input int lat,
                     input bit rv, input logic [31:0] addr,
                     input bit iv, input logic [31:0] instr, input logic [31:0] pc,
                     input bit mis);
    vec_t v;
    v.ps = ps; v.tg = tg; v.al = al; v.rr = rr; v.ir = ir; v.lat = lat;
    v.rv = rv; v.addr = addr; v.iv = iv; v.instr = instr; v.pc = pc; v.mis = mis;
    vecs.push_back(v);
  endtask

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    int sel;
    sel = $urandom_range(0, 9);
    t = $urandom();
    if (sel == 0) t = 32'hFFFF_FFF8;
    else if (sel == 1) t = 32'hFFFF_FFFC;
`ifdef CPU_FETCH_MISALIGN_EN
    t[1:0] = 2'b00;
`endif
    return t;
  endfunction

  initial begin
    // ---------------- directed table ----------------
    //  ps    tg            al           rr ir lat rv addr          iv instr               pc            mis
    add(2'd0, 32'h0,        32'h0,        1, 1, 1, 1, 32'h0,        0, 32'h0,              32'h0,        0);
    add(2'd0, 32'h0,        32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0,              32'h0,        0);
    for (int k = 0; k < 5; k++)
      add(2'd0, 32'h0,      32'h0,        1, 0, 1, 0, 32'h0,        1, XMASK,              32'h0,        0);
    add(2'd0, 32'h0,        32'h0,        1, 1, 1, 1, 32'h4,        1, XMASK,              32'h0,        0);
    add(2'd0, 32'h0,        32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0,              32'h0,        0);
    add(2'd0, 32'h0,        32'h0,        1, 1, 1, 1, 32'h8,        1, XMASK | 32'h4,      32'h4,        0);
    add(2'd0, 32'h0,        32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0,              32'h0,        0);
    add(2'd0, 32'h0,        32'h0,        1, 1, 3, 1, 32'hC,        1, XMASK | 32'h8,      32'h8,        0);
    add(2'd1, 32'h100,      32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0,              32'h0,        0);
    add(2'd0, 32'h0,        32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0,              32'h0,        0);
    add(2'd0, 32'h0,        32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0,              32'h0,        0);
    add(2'd0, 32'h0,        32'h0,        1, 1, 1, 1, 32'h100,      0, 32'h0,              32'h0,        0);
    add(2'd0, 32'h0,        32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0,              32'h0,        0);
    add(2'd0, 32'h0,        32'h0,        1, 1, 1, 1, 32'h104,      1, 32'hA5A5_0100,      32'h100,      0);
    add(2'd2, 32'h300,      32'h200,      1, 1, 1, 0, 32'h0,        0, 32'h0,              32'h0,        0);
    add(2'd0, 32'h0,        32'h0,        1, 1, 1, 1, 32'h200,      0, 32'h0,              32'h0,        0);
    add(2'd0, 32'h0,        32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0,              32'h0,        0);
    add(2'd0, 32'h0,        32'h0,        0, 1, 1, 1, 32'h204,      1, 32'hA5A5_0200,      32'h200,      0);
    add(2'd0, 32'h0,        32'h0,        0, 1, 1, 1, 32'h204,      0, 32'h0,              32'h0,        0);
    add(2'd1, 32'h102,      32'h202,      0, 0, 1, 0, 32'h0,        0, 32'h0,              32'h0,        0);
`ifdef CPU_FETCH_MISALIGN_EN
    add(2'd0, 32'h0,        32'h0,        0, 0, 1, 0, 32'h0,        1, 32'h13,             32'h102,      1);
    add(2'd1, 32'hFFFF_FFFC, 32'h0,       1, 1, 1, 0, 32'h0,        1, 32'h13,             32'h102,      1);
`else
    add(2'd0, 32'h0,        32'h0,        0, 0, 1, 1, 32'h100,      0, 32'h0,              32'h0,        0);
    add(2'd1, 32'hFFFF_FFFC, 32'h0,       1, 1, 1, 0, 32'h0,        0, 32'h0,              32'h0,        0);
`endif
    add(2'd0, 32'h0,        32'h0,        1, 1, 1, 1, 32'hFFFF_FFFC, 0, 32'h0,             32'h0,        0);
    add(2'd0, 32'h0,        32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0,              32'h0,        0);
    add(2'd0, 32'h0,        32'h0,        1, 1, 1, 1, 32'h0,        1, 32'h5A5A_FFFC,      32'hFFFF_FFFC, 0);

    #2;
    do_reset();
    foreach (vecs[i]) begin
      pc_src = vecs[i].ps; pc_target = vecs[i].tg; alu_result = vecs[i].al;
      imem_req_ready = vecs[i].rr; if_ready = vecs[i].ir;
      #1;
      check($sformatf("row%0d_req_valid", i), imem_req_valid, vecs[i].rv);
      if (vecs[i].rv) check($sformatf("row%0d_req_addr", i), imem_req_addr, vecs[i].addr);
      check($sformatf("row%0d_if_valid", i), if_valid, vecs[i].iv);
      if (vecs[i].iv) begin
        check($sformatf("row%0d_if_instr", i), if_instr, vecs[i].instr);
        check($sformatf("row%0d_if_pc", i), if_pc, vecs[i].pc);
        check($sformatf("row%0d_pc_plus_4", i), if_pc_plus_4, vecs[i].pc + 32'd4);
`ifdef CPU_FETCH_MISALIGN_EN
        check($sformatf("row%0d_misalign", i), if_misalign, vecs[i].mis);
`endif
      end
      advance(vecs[i].lat);
    end

    // ---------------- reset asserted mid-WAIT ----------------
    do_reset();
    pc_src = 2'b00; imem_req_ready = 1'b1; if_ready = 1'b0;
    #1; check("rstw_first_addr", imem_req_addr, RESET_PC);
    advance(1);
    #1; advance(1);
    if_ready = 1'b1;
    #1; check("rstw_buf_before", if_instr, XMASK);
    advance(3);                               // request for 4 now outstanding
    imem_req_ready = 1'b0;
    #1; rst_n = 1'b0; #1;
    check("rstw_req_valid", imem_req_valid, 1'b0);
    check("rstw_if_valid", if_valid, 1'b0);
    check("rstw_if_instr", if_instr, 32'h0);
    check("rstw_if_pc", if_pc, 32'h0);
    advance(1);
    #1; advance(1);
    rst_n = 1'b1;                             // late response arrives now
    #1;
    check("rstw_late_resp_present", imem_resp_valid, 1'b1);
    check("rstw_req_valid_after", imem_req_valid, 1'b1);
    check("rstw_req_addr_after", imem_req_addr, RESET_PC);
    advance(1);
    #1;
    check("rstw_late_ignored", if_valid, 1'b0);
    imem_req_ready = 1'b1;
    advance(1);
    #1; advance(1);
    #1;
    check("rstw_refetch_valid", if_valid, 1'b1);
    check("rstw_refetch_instr", if_instr, XMASK);
    check("rstw_refetch_pc", if_pc, RESET_PC);

    // ---------------- randomized against transaction model ----------------
    begin
      int          epoch, req_epoch, delivered, r, lat;
      bit          outstanding, redir, fire;
      logic [31:0] exp_addr, req_addr, tgt;
      ent_t        q[$];
      ent_t        e;
      epoch = 0; req_epoch = -1; delivered = 0;
      outstanding = 1'b0; exp_addr = RESET_PC; req_addr = '0;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
        r = $urandom_range(0, 99);
        pc_src = (r < 6) ? 2'd1 : (r < 12) ? 2'd2 : (r < 16) ? 2'd3 : 2'd0;
        pc_target  = rand_target();
        alu_result = rand_target();
        imem_req_ready = ($urandom_range(0, 3) != 0);
        if_ready       = ($urandom_range(0, 2) != 0);
        lat = $urandom_range(1, 3);
        #1;
        redir = (pc_src == 2'd1) || (pc_src == 2'd2);
        tgt   = (pc_src == 2'd2) ? alu_result : pc_target;
        fire  = imem_req_valid && imem_req_ready;

        check("rnd_if_valid", if_valid, q.size() != 0);
        if (if_valid) check("rnd_pc_plus_4", if_pc_plus_4, if_pc + 32'd4);
        if (fire) begin
          check("rnd_one_outstanding", outstanding, 1'b0);
          check("rnd_req_addr", imem_req_addr, exp_addr);
        end
        if (if_valid && if_ready && !redir && q.size() != 0) begin
          check("rnd_dec_pc", if_pc, q[0].pc);
          check("rnd_dec_instr", if_instr, q[0].instr);
          void'(q.pop_front());
          delivered++;
        end

        if (imem_resp_valid) begin
          if (!redir && req_epoch == epoch) begin
            e.pc = req_addr; e.instr = req_addr ^ XMASK;
            q.push_back(e);
            check("rnd_buf_depth", q.size() <= 1, 1'b1);
            exp_addr = req_addr + 32'd4;
          end
          outstanding = 1'b0;
        end
        if (redir) begin
          epoch++;
          exp_addr = tgt & ~32'd3;
          q.delete();
        end
        if (fire) begin
          outstanding = 1'b1;
          req_epoch   = epoch;
          req_addr    = imem_req_addr;
        end
        advance(lat);
      end
      check("rnd_progress", delivered > 50, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
